// File: rtl/approx_mul8_seq_sched.sv
// Sequential 8x8 multiplier scheduler that time-shares one external 4x4 approximate
// sub-multiplier, one quadrant per cycle. Optional macro SKIP_ZERO_EN skips zero-nibble quadrants.
module approx_mul8_seq_sched #(
  parameter int unsigned NW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*NW-1:0]   in_a,
  input  logic [2*NW-1:0]   in_b,
  output logic [NW-1:0]     mul_a,
  output logic [NW-1:0]     mul_b,
  output logic [1:0]        mul_sel,
  input  logic [2*NW-1:0]   mul_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NW-1:0]   out_prod,
  output logic              busy
);

  localparam int unsigned OW = 2 * NW;
  localparam int unsigned RW = 4 * NW;

  typedef enum logic [2:0] {StIdle, StLl, StLh, StHl, StHh, StDone} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   op_a_q, op_b_q;
  logic [OW-1:0]   src_a, src_b;
  logic [RW-1:0]   acc_q, pp_shifted;
  logic [3:0]      keep;
  logic [1:0]      q_d;
  logic            issue_d, issuing;

  function automatic logic [NW-1:0] nib(input logic hi, input logic [OW-1:0] v);
    return hi ? v[OW-1:NW] : v[NW-1:0];
  endfunction

  // First quadrant at or after 'start' that is still to be issued, else DONE.
  function automatic state_e seek(input logic [3:0] k, input int start);
    state_e r;
    r = StDone;
    for (int q = 3; q >= 0; q--) begin
      if (q >= start && k[q]) r = state_e'(3'(q + 1));
    end
    return r;
  endfunction

  always_comb begin
    // At accept the skip decision must look at the live operands.
    src_a = (state_q == StIdle) ? in_a : op_a_q;
    src_b = (state_q == StIdle) ? in_b : op_b_q;
`ifdef SKIP_ZERO_EN
    for (int q = 0; q < 4; q++) begin
      keep[q] = (nib(q[1], src_a) != '0) && (nib(q[0], src_b) != '0);
    end
`else
    keep = 4'b1111;
`endif
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = seek(keep, 0);
      StLl:    state_d = seek(keep, 1);
      StLh:    state_d = seek(keep, 2);
      StHl:    state_d = seek(keep, 3);
      StHh:    state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue_d = 1'b1;
    q_d     = 2'd0;
    unique case (state_d)
      StLl:    q_d = 2'd0;
      StLh:    q_d = 2'd1;
      StHl:    q_d = 2'd2;
      StHh:    q_d = 2'd3;
      default: issue_d = 1'b0;
    endcase
    issuing = (state_q != StIdle) && (state_q != StDone);
    unique case (mul_sel)
      2'd0:    pp_shifted = {{OW{1'b0}}, mul_prod};
      2'd3:    pp_shifted = {{OW{1'b0}}, mul_prod} << (2 * NW);
      default: pp_shifted = {{OW{1'b0}}, mul_prod} << NW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_sel   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        op_a_q <= in_a;
        op_b_q <= in_b;
        acc_q  <= '0;
      end else if (issuing) begin
        acc_q <= acc_q + pp_shifted;
      end
      in_ready  <= (state_d == StIdle);
      busy      <= (state_d != StIdle);
      out_valid <= (state_d == StDone);
      // Issue outputs are registered for the state being entered.
      if (issue_d) begin
        mul_sel <= q_d;
        mul_a   <= nib(q_d[1], src_a);
        mul_b   <= nib(q_d[0], src_b);
      end else begin
        mul_sel <= 2'd0;
        mul_a   <= '0;
        mul_b   <= '0;
      end
    end
  end

  assign out_prod = acc_q;

endmodule

// File: tb/tb_approx_mul8_seq_sched.sv
// Randomized self-checking bench for approx_mul8_seq_sched against a quadrant-sum model;
// honours SKIP_ZERO_EN when defined.
module tb_approx_mul8_seq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  mul_a, mul_b;
  logic [1:0]  mul_sel;
  logic [7:0]  mul_prod;
  logic        out_valid, out_ready;
  logic [15:0] out_prod;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int amode  = 0;  // 0 exact, 1 +1 on HH only, 2 +sel on every quadrant

  always #5 clk = ~clk;

  approx_mul8_seq_sched #(.NW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_sel   (mul_sel),
    .mul_prod  (mul_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  function automatic logic [7:0] approx(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    r = 8'(x * y);
    if (amode == 1 && s == 2'd3) r = r + 8'd1;
    if (amode == 2) r = r + 8'(s);
    return r;
  endfunction

  always_comb mul_prod = approx(mul_sel, mul_a, mul_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected issue list {sel, a_nib, b_nib} in fixed quadrant order.
  function automatic void expect_issues(input logic [7:0] a, input logic [7:0] b,
                                        output logic [9:0] iss[$], output logic [15:0] prod);
    logic [3:0] an, bn;
    int sh;
    iss = {};
    prod = 16'd0;
    for (int q = 0; q < 4; q++) begin
      an = (q >= 2) ? a[7:4] : a[3:0];
      bn = (q == 1 || q == 3) ? b[7:4] : b[3:0];
      sh = (q == 0) ? 0 : (q == 3) ? 8 : 4;
`ifdef SKIP_ZERO_EN
      if (an == 4'd0 || bn == 4'd0) continue;
`endif
      iss.push_back({2'(q), an, bn});
      prod = prod + (16'(approx(2'(q), an, bn)) << sh);
    end
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [9:0]  iss[$];
    logic [15:0] exp;
    int n;
    expect_issues(a, b, iss, exp);
    @(negedge clk);
    check_eq("idle_ready", {31'd0, in_ready}, 32'd1);
    check_eq("idle_sel", {28'd0, mul_sel, mul_a[1:0]}, 32'd0);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) break;
      if (n < iss.size()) check_eq("issue", {22'd0, mul_sel, mul_a, mul_b}, {22'd0, iss[n]});
      else check_eq("extra_issue", 32'd1, 32'd0);
      check_eq("busy_ready", {30'd0, busy, in_ready}, 32'd2);
      n++;
    end
    check_eq("valid_seen", {31'd0, out_valid}, 32'd1);
    check_eq("latency", n, iss.size());
    check_eq("prod", {16'd0, out_prod}, {16'd0, exp});
    for (int s = 0; s < stall; s++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check_eq("stall_hold", {14'd0, out_valid, in_ready, out_prod}, {14'd0, 2'b10, exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("released", {29'd0, out_valid, busy, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #2;
    check_eq("rst_flags", {29'd0, in_ready, busy, out_valid}, 32'd4);
    check_eq("rst_mul", {22'd0, mul_sel, mul_a, mul_b}, 32'd0);
    check_eq("rst_prod", {16'd0, out_prod}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    amode = 0;
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h12, 8'h34, 0);
    run_op(8'hA7, 8'h3C, 5);
    run_op(8'h5B, 8'hE2, 0);

    // Abort mid-sequence while HL is being issued.
    @(negedge clk);
    in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_abort_sel", {30'd0, mul_sel}, 32'd2);
    rst = 1'b1;
    #1;
    check_eq("abort_flags", {28'd0, in_ready, busy, out_valid, 1'b0}, 32'd8);
    check_eq("abort_mul", {22'd0, mul_sel, mul_a, mul_b}, 32'd0);
    check_eq("abort_prod", {16'd0, out_prod}, 32'd0);
    #2 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check_eq("abort_no_result", seen, 0);

    amode = 1;
    run_op(8'h11, 8'h11, 0);
    check_eq("hh_tag", {16'd0, out_prod}, 32'h0221);

    amode = 0;
    run_op(8'h0F, 8'h0F, 0);
    run_op(8'h00, 8'h5A, 1);
    run_op(8'hF0, 8'h0F, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      amode = int'($urandom_range(0, 2));
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) a[3:0] = 4'd0;
      if ($urandom_range(0, 5) == 0) b[7:4] = 4'd0;
      run_op(a, b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
